// File: rtl/rf_sequencer.sv
// Multicycle instruction sequencer in front of a 4x8-bit register file.
// Moore FSM: IDLE -> DECODE -> (EXEC | IMM) -> WB, with sticky illegal-opcode error.
module rf_sequencer (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] dataA,
    input  logic [7:0] dataB,
    output logic [1:0] regA,
    output logic [1:0] regB,
    output logic [1:0] regW,
    output logic [7:0] dataW,
    output logic       RFWrite,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_c,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_IMM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_LI   = 4'd7;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_ir;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_result;
    logic       r_z;
    logic       r_n;
    logic       r_c;
    logic       r_nz;
    logic       r_nn;
    logic       r_nc;
    logic       r_err;

    logic [3:0] w_op;
    logic       w_illegal;
    logic       w_flagop;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_alu_res;
    logic       w_alu_c;

    assign w_op      = r_ir[7:4];
    assign w_illegal = w_op[3];
    assign w_flagop  = (w_op >= OP_ADD) && (w_op <= OP_SHR);
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff    = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_alu_res = r_b;
        w_alu_c   = 1'b0;
        case (w_op)
            OP_MOV:  w_alu_res = r_b;
            OP_ADD:  begin w_alu_res = w_sum[7:0];  w_alu_c = w_sum[8];  end
            OP_SUB:  begin w_alu_res = w_diff[7:0]; w_alu_c = w_diff[8]; end
            OP_NAND: w_alu_res = ~(r_a & r_b);
            OP_SHL:  begin w_alu_res = {r_a[6:0], 1'b0}; w_alu_c = r_a[7]; end
            OP_SHR:  begin w_alu_res = {1'b0, r_a[7:1]}; w_alu_c = r_a[0]; end
            default: begin w_alu_res = r_b; w_alu_c = 1'b0; end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (instr_valid) w_next = S_DECODE;
            S_DECODE: begin
                if (w_op == OP_LI)
                    w_next = S_IMM;
                else if (w_illegal || (w_op == OP_NOP))
                    w_next = S_IDLE;
                else
                    w_next = S_EXEC;
            end
            S_EXEC:   w_next = S_WB;
            S_IMM:    if (instr_valid) w_next = S_WB;
            S_WB:     w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Flags are staged in EXEC and only become architectural in WB, so a reset
    // before write-back can never leave a partial flag update behind.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_ir     <= 8'h00;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_result <= 8'h00;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_nz     <= 1'b0;
            r_nn     <= 1'b0;
            r_nc     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE:   if (instr_valid) r_ir <= instr;
                S_DECODE: begin
                    r_a <= dataA;
                    r_b <= dataB;
                    if (w_illegal) r_err <= 1'b1;
                end
                S_EXEC: begin
                    r_result <= w_alu_res;
                    r_nz     <= (w_alu_res == 8'h00);
                    r_nn     <= w_alu_res[7];
                    r_nc     <= w_alu_c;
                end
                S_IMM:    if (instr_valid) r_result <= instr;
                S_WB: begin
                    if (w_flagop) begin
                        r_z <= r_nz;
                        r_n <= r_nn;
                        r_c <= r_nc;
                    end
                end
                default: ;
            endcase
        end
    end

    // err is visible in the same cycle as the illegal opcode's done pulse.
    assign instr_ready = (r_state == S_IDLE) || (r_state == S_IMM);
    assign regA        = r_ir[3:2];
    assign regB        = r_ir[1:0];
    assign regW        = r_ir[3:2];
    assign dataW       = r_result;
    assign RFWrite     = (r_state == S_WB);
    assign done        = (r_state == S_WB) ||
                         ((r_state == S_DECODE) && (w_illegal || (w_op == OP_NOP)));
    assign err         = r_err || ((r_state == S_DECODE) && w_illegal);
    assign flag_z      = r_z;
    assign flag_n      = r_n;
    assign flag_c      = r_c;

endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Multicycle instruction sequencer that sits directly upstream of the 4×8-bit register file. It accepts 8-bit instructions over a valid/ready handshake and drives the register file's read selects (regA/regB). It computes an 8-bit ALU result from the returned dataA/dataB and writes the result back through RFWrite/regW/dataW. Condition flags are maintained for a later branch stage.

## Interface
- No parameters; data width fixed at 8, register count fixed at 4.
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- instr  in  8  instruction byte, or LI immediate byte.
- instr_valid  in  1  instr holds a valid byte this cycle.
- instr_ready  out  1  sequencer can accept a byte this cycle.
- dataA  in  8  register-file read port A (combinational read).
- dataB  in  8  register-file read port B.
- regA  out  2  read select A; always equals rx of the current instruction.
- regB  out  2  read select B; always equals ry of the current instruction.
- regW  out  2  write select; always equals rx.
- dataW  out  8  write data, driven from the result register.
- RFWrite  out  1  write enable, high for exactly one cycle per writing instruction.
- flag_z, flag_n, flag_c  out  1 each  zero, negative and carry/borrow flags.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  sticky illegal-opcode indicator; cleared only by reset.

## Operation
- Instruction format: opcode = instr[7:4], rx = instr[3:2], ry = instr[1:0].
- Opcodes:
  - 0 NOP
  - 1 MOV: rx←ry
  - 2 ADD: rx←rx+ry
  - 3 SUB: rx←rx−ry
  - 4 NAND: rx←~(rx&ry)
  - 5 SHL: rx←rx<<1, zero fill
  - 6 SHR: rx←rx>>1, logical
  - 7 LI: rx←next accepted byte
  - 8–F: illegal
- Arithmetic is 8-bit modulo 256. The result is truncated to 8 bits.
- Flag updates (applied at write-back):
  - ADD/SUB/NAND/SHL/SHR update Z = (result==0) and N = result[7].
  - C for ADD = carry out of bit 7.
  - C for SUB = borrow (1 iff rx<ry, unsigned).
  - C for SHL = old rx[7]; C for SHR = old rx[0]; C for NAND = 0.
  - MOV, LI and NOP leave all flags unchanged.
- Illegal opcode: err←1, no register write, done pulses, return to IDLE.
- The FSM is Moore. All outputs are decoded from the state and internal registers.
- States:
  - IDLE: instr_ready=1. On instr_valid, capture instr into IR → DECODE.
  - DECODE: regA/regB present rx/ry. Latch dataA→A and dataB→B. Next state:
    - LI → IMM
    - NOP/illegal → IDLE, with done=1 this cycle
    - otherwise → EXEC
  - EXEC: compute result and next flags into registers → WB.
  - IMM: instr_ready=1. On instr_valid, capture instr into the result register → WB. With instr_valid low, wait indefinitely.
  - WB: RFWrite=1, regW=rx, dataW=result, flags commit, done=1 → IDLE.
- instr_ready is low in DECODE, EXEC and WB. Bytes presented in those states are not consumed.
- Reset values (asynchronous, on resetn low):
  - state = IDLE; IR, A, B and result = 0
  - RFWrite = 0, done = 0, err = 0
  - all flags = 0
  - regA/regB/regW = 0, dataW = 0
  - instr_ready = 1 once resetn deasserts
- Reset mid-instruction aborts it. No RFWrite is issued, and no partial flag update occurs.

## Timing
- The handshake completes on a rising edge where instr_valid & instr_ready are both high.
- ALU op: accept at edge 0, DECODE in cycle 1, EXEC in cycle 2, WB in cycle 3. The register is updated at the end of cycle 3, and instr_ready rises in cycle 4. Throughput is one op per 4 cycles.
- LI: DECODE in cycle 1, IMM from cycle 2 until the immediate is accepted, then WB the following cycle. Minimum 4 cycles.
- NOP/illegal: done pulses in cycle 1; ready again in cycle 2.
- Back-to-back dependency: a write in WB is visible on dataA/dataB in the next instruction's DECODE. No forwarding is needed.
- dataA/dataB are sampled only in DECODE. Changes in other cycles are ignored.

## Test plan
- Reset, then LI r1,0x05 (0x74, 0x05): RFWrite pulses once in the 4th cycle with regW=1 and dataW=0x05; flags stay 0.
- LI r1,0x05; LI r2,0xFB; ADD r1,r2 (0x26): dataW=0x00, Z=1, N=0, C=1.
- r0=0x03, r3=0x05; SUB r0,r3 (0x33): dataW=0xFE, N=1, C=1, Z=0. Then SHR r0 (0x60): dataW=0x7F, C=0, N=0.
- Opcode 0xF0: err=1 and done pulses in cycle 1; RFWrite stays 0; flags unchanged. A subsequent MOV still executes, and err stays 1.
- LI with instr_valid held low for 5 cycles after the opcode: FSM holds in IMM with instr_ready=1 and no RFWrite. The immediate 0xA5 is then written exactly once.
- resetn pulsed low during EXEC of ADD: RFWrite never asserts, the target register is unchanged, outputs return to reset values immediately, and instr_ready=1 once resetn deasserts.
